// File: rtl/sync_pulse_meter.sv
// Rising-edge event counter and interval meter with a small measurement FIFO.
// Optional edge hold-off after each accepted edge: define SYNC_PULSE_METER_HOLDOFF_EN.
module sync_pulse_meter #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLDOFF    = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] meas_data,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] event_count,
  output logic             overflow,
  output logic             dropped
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  if (HOLDOFF < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("sync_pulse_meter: HOLDOFF must be >= 1, FIFO_DEPTH a power of 2 >= 2");
  end

`ifdef SYNC_PULSE_METER_HOLDOFF_EN
  localparam int HOLD_W = $clog2(HOLDOFF + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    S_WAIT_FIRST = 2'd0,
    S_MEASURE    = 2'd1,
    S_HOLDOFF    = 2'd2
  } state_t;

  logic [HOLD_W-1:0] hold_cnt;
`else
  typedef enum logic [1:0] {
    S_WAIT_FIRST = 2'd0,
    S_MEASURE    = 2'd1
  } state_t;
`endif

  state_t state, next_state;

  logic             pulse_d;
  logic             rise;
  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic             do_push;
  logic [CNT_W-1:0] cnt;

  logic [CNT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  assign rise = pulse_in & ~pulse_d;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= S_WAIT_FIRST;
      pulse_d <= 1'b0;
    end else begin
      state   <= next_state;
      pulse_d <= pulse_in;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    push       = 1'b0;
    case (state)
      S_WAIT_FIRST: begin
        if (rise) begin
          accept = 1'b1;
`ifdef SYNC_PULSE_METER_HOLDOFF_EN
          next_state = S_HOLDOFF;
`else
          next_state = S_MEASURE;
`endif
        end
      end
      S_MEASURE: begin
        if (rise) begin
          accept = 1'b1;
          push   = 1'b1;
`ifdef SYNC_PULSE_METER_HOLDOFF_EN
          next_state = S_HOLDOFF;
`else
          next_state = S_MEASURE;
`endif
        end
      end
`ifdef SYNC_PULSE_METER_HOLDOFF_EN
      S_HOLDOFF: begin
        if (hold_cnt == '0) next_state = S_MEASURE;
      end
`endif
      default: next_state = S_WAIT_FIRST;
    endcase
  end

`ifdef SYNC_PULSE_METER_HOLDOFF_EN
  // Loaded with HOLDOFF-1 so the state lasts exactly HOLDOFF cycles.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hold_cnt <= '0;
    end else if (accept) begin
      hold_cnt <= HOLD_LOAD;
    end else if (state == S_HOLDOFF && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HOLD_ONE;
    end
  end
`endif

  // ------------------------------------------------- interval and events
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      cnt <= CNT_ONE;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
      if (cnt == CNT_MAX - CNT_ONE) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      event_count <= '0;
    end else if (accept) begin
      event_count <= event_count + CNT_ONE;
    end
  end

  // ------------------------------------------------------- measurement FIFO
  assign meas_valid = (occ != '0);
  assign full       = (occ == OCC_FULL);
  assign pop        = meas_valid & meas_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push    = push & (~full | pop);
  assign meas_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= cnt;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      dropped <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
      if (push && full && !pop) dropped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_pulse_meter.sv
// Directed scoreboard bench for sync_pulse_meter (default 16-bit instance plus a 4-bit
// instance for saturation); expectations follow SYNC_PULSE_METER_HOLDOFF_EN when defined.
module tb_sync_pulse_meter;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        pulse_a = 1'b0;
  logic        ready_a = 1'b0;
  logic [15:0] data_a;
  logic        valid_a;
  logic [15:0] events_a;
  logic        ovf_a;
  logic        drop_a;

  logic        pulse_b = 1'b0;
  logic        ready_b = 1'b0;
  logic [3:0]  data_b;
  logic        valid_b;
  logic [3:0]  events_b;
  logic        ovf_b;
  logic        drop_b;

  int unsigned q_a[$];
  int unsigned q_b[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned valid_cycles = 0;
  int unsigned last_valid_cyc = 0;

  always #5 clk = ~clk;

  sync_pulse_meter #(.CNT_W(16), .FIFO_DEPTH(4), .HOLDOFF(4)) dut_a (
    .clk(clk), .clr(clr), .pulse_in(pulse_a), .meas_data(data_a), .meas_valid(valid_a),
    .meas_ready(ready_a), .event_count(events_a), .overflow(ovf_a), .dropped(drop_a)
  );

  sync_pulse_meter #(.CNT_W(4), .FIFO_DEPTH(4), .HOLDOFF(4)) dut_b (
    .clk(clk), .clr(clr), .pulse_in(pulse_b), .meas_data(data_b), .meas_valid(valid_b),
    .meas_ready(ready_b), .event_count(events_b), .overflow(ovf_b), .dropped(drop_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock cycle: inputs were set after the previous posedge; outputs sampled at negedge.
  task automatic tick();
    int unsigned e;
    @(negedge clk);
    if (valid_a) begin
      valid_cycles++;
      last_valid_cyc = cyc;
    end
    if (valid_a && ready_a) begin
      if (q_a.size() == 0) check("a_unexpected_valid", valid_a, 0);
      else begin
        e = q_a.pop_front();
        check("a_meas_data", data_a, e);
      end
    end
    if (valid_b && ready_b) begin
      if (q_b.size() == 0) check("b_unexpected_valid", valid_b, 0);
      else begin
        e = q_b.pop_front();
        check("b_meas_data", data_b, e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int unsigned len);
    pulse_a = 1'b1;
    idle(len);
    pulse_a = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    pulse_a = 1'b0;
    pulse_b = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    tick();
    clr = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_valid", valid_a, 0);
    check("rst_events", events_a, 0);
    check("rst_overflow", ovf_a, 0);
    check("rst_dropped", drop_a, 0);

    // Edges at cycles 10 and 35 -> single measurement 25, valid in cycle 36 only
    ready_a = 1'b1;
    do_reset();
    valid_cycles = 0;
    idle(10);
    pulse(1);
    idle(24);
    q_a.push_back(25);
    pulse(1);
    idle(6);
    check("t2_valid_cycles", valid_cycles, 1);
    check("t2_valid_cycle", last_valid_cyc, 36);
    check("t2_events", events_a, 2);

    // Pulse held high 3 cycles counts once
    do_reset();
    pulse(3);
    idle(1);
    check("t3_events_one", events_a, 1);
    idle(9);
    q_a.push_back(13);
    pulse(3);
    idle(3);
    check("t3_events_two", events_a, 2);
    check("t3_drained", q_a.size(), 0);

    // Edge 2 cycles after an accepted edge
    do_reset();
    pulse(1);
    idle(1);
`ifndef SYNC_PULSE_METER_HOLDOFF_EN
    q_a.push_back(2);
`endif
    pulse(1);
    idle(17);
`ifdef SYNC_PULSE_METER_HOLDOFF_EN
    q_a.push_back(20);
`else
    q_a.push_back(18);
`endif
    pulse(1);
    idle(3);
`ifdef SYNC_PULSE_METER_HOLDOFF_EN
    check("t4_events", events_a, 2);
`else
    check("t4_events", events_a, 3);
`endif
    check("t4_drained", q_a.size(), 0);

    // FIFO full: intervals 10..15 with consumer stalled, then drain
    ready_a = 1'b0;
    do_reset();
    pulse(1);
    for (int unsigned k = 10; k <= 15; k++) begin
      idle(k - 1);
      if (k == 14) check("t5_dropped_before", drop_a, 0);
      if (k <= 13) q_a.push_back(k);
      pulse(1);
    end
    idle(1);
    check("t5_dropped", drop_a, 1);
    check("t5_events", events_a, 7);
    check("t5_valid_full", valid_a, 1);
    ready_a = 1'b1;
    valid_cycles = 0;
    idle(6);
    check("t5_valid_cycles", valid_cycles, 4);
    check("t5_valid_after", valid_a, 0);
    check("t5_drained", q_a.size(), 0);

    // Mid-run clear with two entries queued
    ready_a = 1'b0;
    idle(5);
    pulse(1);
    idle(9);
    pulse(1);
    idle(2);
    check("t1_valid_before", valid_a, 1);
    check("t1_events_before", events_a, 9);
    clr = 1'b1;
    #1;
    check("t1_valid", valid_a, 0);
    check("t1_events", events_a, 0);
    check("t1_overflow", ovf_a, 0);
    check("t1_dropped", drop_a, 0);
    tick();
    clr = 1'b0;
    q_a.delete();
    ready_a = 1'b1;
    valid_cycles = 0;
    idle(3);
    pulse(1);
    idle(8);
    check("t1_no_push", valid_cycles, 0);
    check("t1_events_after", events_a, 1);

    // 4-bit counter saturation, then a normal interval
    ready_b = 1'b1;
    do_reset();
    pulse_b = 1'b1;
    tick();
    pulse_b = 1'b0;
    idle(10);
    check("t6_overflow_before", ovf_b, 0);
    idle(9);
    q_b.push_back(15);
    pulse_b = 1'b1;
    tick();
    pulse_b = 1'b0;
    idle(4);
    q_b.push_back(5);
    pulse_b = 1'b1;
    tick();
    pulse_b = 1'b0;
    idle(3);
    check("t6_overflow", ovf_b, 1);
    check("t6_events", events_b, 3);
    check("t6_drained", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
